// File: rtl/dict_pkg.sv
// Shared widths, header layout and state encoding for the boot-time dictionary loader.
package dict_pkg;

  localparam int KEY1_W = 3;
  localparam int KEY2_W = 8;
  localparam int KEY3_W = 5;
  localparam int VAL1_W = 7;
  localparam int VAL2_W = 15;
  localparam int VAL3_W = 10;
  localparam int CNT_W  = 10;

  localparam int HDR_N1_LSB = 0;
  localparam int HDR_N1_MSB = 9;
  localparam int HDR_N2_LSB = 10;
  localparam int HDR_N2_MSB = 19;
  localparam int HDR_N3_LSB = 20;
  localparam int HDR_N3_MSB = 29;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    F1   = 3'd2,
    F2   = 3'd3,
    F3   = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_e;

  // First field (in image order) that still has entries to fetch.
  function automatic state_e first_field(input logic has1, input logic has2, input logic has3);
    if (has1) begin
      return F1;
    end else if (has2) begin
      return F2;
    end else if (has3) begin
      return F3;
    end else begin
      return DONE;
    end
  endfunction

endpackage

// File: rtl/dict_mem_mux.sv
// Memory-port mux: the loader owns the port until load_done, then the controller
// is wired straight through with no added latency.
module dict_mem_mux (
  input  logic        sel_ctrl,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        ctrl_valid,
  input  logic [31:0] ctrl_addr,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic        ctrl_ready,
  output logic [31:0] ctrl_rdata
);

  // Select port owner; the controller is stalled (ready=0) while the loader owns it.
  always_comb begin
    mem_valid  = 1'b0;
    mem_addr   = 32'h0000_0000;
    ctrl_ready = 1'b0;
    ctrl_rdata = 32'h0000_0000;
    if (sel_ctrl) begin
      mem_valid  = ctrl_valid;
      mem_addr   = ctrl_addr;
      ctrl_ready = mem_ready;
      ctrl_rdata = mem_rdata;
    end else begin
      mem_valid  = ld_valid;
      mem_addr   = ld_addr;
      ctrl_ready = 1'b0;
      ctrl_rdata = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/dict_loader.sv
// Boot-time dictionary loader: reads a header plus three entry lists from instruction
// memory, pulses them into the field dictionaries, then hands the port to the controller.
module dict_loader
  import dict_pkg::*;
#(
  parameter int          FIELD1_KEY_WIDTH = KEY1_W,
  parameter int          FIELD2_KEY_WIDTH = KEY2_W,
  parameter int          FIELD3_KEY_WIDTH = KEY3_W,
  parameter int          FIELD1_VAL_WIDTH = VAL1_W,
  parameter int          FIELD2_VAL_WIDTH = VAL2_W,
  parameter int          FIELD3_VAL_WIDTH = VAL3_W,
  parameter logic [31:0] DICT_BASE_ADDR   = 32'h0000_1000,
  parameter bit          AUTO_START       = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [31:0]                 mem_req_addr,
  input  logic [31:0]                 mem_req_rdata,
  input  logic                        ctrl_mem_req_valid,
  output logic                        ctrl_mem_req_ready,
  input  logic [31:0]                 ctrl_mem_req_addr,
  output logic [31:0]                 ctrl_mem_req_rdata,
  output logic                        dict1_write_enable,
  output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
  output logic                        dict2_write_enable,
  output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
  output logic                        dict3_write_enable,
  output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val,
  output logic                        load_done,
  output logic                        load_error,
  output logic [CNT_W-1:0]            entries_loaded
);

  localparam logic [CNT_W:0] CAP1 = (CNT_W+1)'(2 ** FIELD1_KEY_WIDTH);
  localparam logic [CNT_W:0] CAP2 = (CNT_W+1)'(2 ** FIELD2_KEY_WIDTH);
  localparam logic [CNT_W:0] CAP3 = (CNT_W+1)'(2 ** FIELD3_KEY_WIDTH);

  state_e                      state_r, state_nx_s;
  logic [31:0]                 addr_r;
  logic [CNT_W-1:0]            rem1_r, rem2_r, rem3_r;
  logic [CNT_W-1:0]            rem1_nx_s, rem2_nx_s, rem3_nx_s;
  logic                        ld_valid_r, ld_valid_nx_s;
  logic                        load_done_r, load_error_r;
  logic                        wr1_r, wr2_r, wr3_r;
  logic [FIELD1_VAL_WIDTH-1:0] val1_r;
  logic [FIELD2_VAL_WIDTH-1:0] val2_r;
  logic [FIELD3_VAL_WIDTH-1:0] val3_r;
  logic [CNT_W-1:0]            entries_r;
  logic                        xfer_s, hdr_bad_s, fetch_nx_s;
  logic [CNT_W-1:0]            hdr_n1_s, hdr_n2_s, hdr_n3_s;
  logic [31:0]                 ld_addr_s;

  assign xfer_s    = ld_valid_r & mem_req_ready;
  assign hdr_n1_s  = mem_req_rdata[HDR_N1_MSB:HDR_N1_LSB];
  assign hdr_n2_s  = mem_req_rdata[HDR_N2_MSB:HDR_N2_LSB];
  assign hdr_n3_s  = mem_req_rdata[HDR_N3_MSB:HDR_N3_LSB];
  assign hdr_bad_s = ({1'b0, hdr_n1_s} > CAP1) || ({1'b0, hdr_n2_s} > CAP2) ||
                     ({1'b0, hdr_n3_s} > CAP3);

  // A transfer forces one idle cycle before the next request goes out.
  assign fetch_nx_s    = (state_nx_s == HDR) || (state_nx_s == F1) ||
                         (state_nx_s == F2)  || (state_nx_s == F3);
  assign ld_valid_nx_s = fetch_nx_s && !xfer_s;
  assign ld_addr_s     = ld_valid_r ? addr_r : 32'h0000_0000;

  // Next-state and remaining-count logic.
  always_comb begin
    state_nx_s = state_r;
    rem1_nx_s  = rem1_r;
    rem2_nx_s  = rem2_r;
    rem3_nx_s  = rem3_r;
    case (state_r)
      IDLE: begin
        if (AUTO_START || start) state_nx_s = HDR;
        else                     state_nx_s = IDLE;
      end
      HDR: begin
        if (xfer_s && hdr_bad_s) begin
          state_nx_s = ERR;
        end else if (xfer_s) begin
          rem1_nx_s  = hdr_n1_s;
          rem2_nx_s  = hdr_n2_s;
          rem3_nx_s  = hdr_n3_s;
          state_nx_s = first_field(|hdr_n1_s, |hdr_n2_s, |hdr_n3_s);
        end else begin
          state_nx_s = HDR;
        end
      end
      F1: begin
        if (xfer_s) begin
          rem1_nx_s = rem1_r - CNT_W'(1);
          if (rem1_r == CNT_W'(1)) state_nx_s = first_field(1'b0, |rem2_r, |rem3_r);
          else                     state_nx_s = F1;
        end else begin
          state_nx_s = F1;
        end
      end
      F2: begin
        if (xfer_s) begin
          rem2_nx_s = rem2_r - CNT_W'(1);
          if (rem2_r == CNT_W'(1)) state_nx_s = first_field(1'b0, 1'b0, |rem3_r);
          else                     state_nx_s = F2;
        end else begin
          state_nx_s = F2;
        end
      end
      F3: begin
        if (xfer_s) begin
          rem3_nx_s = rem3_r - CNT_W'(1);
          if (rem3_r == CNT_W'(1)) state_nx_s = DONE;
          else                     state_nx_s = F3;
        end else begin
          state_nx_s = F3;
        end
      end
      DONE:    state_nx_s = DONE;
      ERR:     state_nx_s = ERR;
      default: state_nx_s = IDLE;
    endcase
  end

  // State, counters, request pointer and sticky status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      addr_r       <= DICT_BASE_ADDR;
      rem1_r       <= {CNT_W{1'b0}};
      rem2_r       <= {CNT_W{1'b0}};
      rem3_r       <= {CNT_W{1'b0}};
      ld_valid_r   <= 1'b0;
      load_done_r  <= 1'b0;
      load_error_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      rem1_r       <= rem1_nx_s;
      rem2_r       <= rem2_nx_s;
      rem3_r       <= rem3_nx_s;
      ld_valid_r   <= ld_valid_nx_s;
      load_done_r  <= (state_nx_s == DONE);
      load_error_r <= (state_nx_s == ERR);
      if (xfer_s) addr_r <= addr_r + 32'd4;
    end
  end

  // Write pulses land the cycle after each entry transfer; count saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr1_r     <= 1'b0;
      wr2_r     <= 1'b0;
      wr3_r     <= 1'b0;
      val1_r    <= {FIELD1_VAL_WIDTH{1'b0}};
      val2_r    <= {FIELD2_VAL_WIDTH{1'b0}};
      val3_r    <= {FIELD3_VAL_WIDTH{1'b0}};
      entries_r <= {CNT_W{1'b0}};
    end else begin
      wr1_r <= xfer_s && (state_r == F1);
      wr2_r <= xfer_s && (state_r == F2);
      wr3_r <= xfer_s && (state_r == F3);
      if (xfer_s && (state_r == F1)) val1_r <= mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
      if (xfer_s && (state_r == F2)) val2_r <= mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
      if (xfer_s && (state_r == F3)) val3_r <= mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
      if (xfer_s && ((state_r == F1) || (state_r == F2) || (state_r == F3)) &&
          (entries_r != {CNT_W{1'b1}}))
        entries_r <= entries_r + CNT_W'(1);
    end
  end

  assign dict1_write_enable = wr1_r;
  assign dict2_write_enable = wr2_r;
  assign dict3_write_enable = wr3_r;
  assign dict1_write_val    = val1_r;
  assign dict2_write_val    = val2_r;
  assign dict3_write_val    = val3_r;
  assign load_done          = load_done_r;
  assign load_error         = load_error_r;
  assign entries_loaded     = entries_r;

  dict_mem_mux u_mux (
    .sel_ctrl   (load_done_r),
    .ld_valid   (ld_valid_r),
    .ld_addr    (ld_addr_s),
    .mem_ready  (mem_req_ready),
    .mem_rdata  (mem_req_rdata),
    .ctrl_valid (ctrl_mem_req_valid),
    .ctrl_addr  (ctrl_mem_req_addr),
    .mem_valid  (mem_req_valid),
    .mem_addr   (mem_req_addr),
    .ctrl_ready (ctrl_mem_req_ready),
    .ctrl_rdata (ctrl_mem_req_rdata)
  );

endmodule

// File: tb/tb_dict_loader.sv
// Self-checking bench for dict_loader: table-driven header cases, random images checked
// against a queue-based image model, plus hand-written reset-abort and passthrough sequences.
module tb_dict_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr, mem_req_rdata;
  logic        ctrl_mem_req_valid = 1'b1;
  logic        ctrl_mem_req_ready;
  logic [31:0] ctrl_mem_req_addr = 32'h0000_0040;
  logic [31:0] ctrl_mem_req_rdata;
  logic        dict1_write_enable, dict2_write_enable, dict3_write_enable;
  logic [6:0]  dict1_write_val;
  logic [14:0] dict2_write_val;
  logic [9:0]  dict3_write_val;
  logic        load_done, load_error;
  logic [9:0]  entries_loaded;

  dict_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rdata(mem_req_rdata),
    .ctrl_mem_req_valid(ctrl_mem_req_valid), .ctrl_mem_req_ready(ctrl_mem_req_ready),
    .ctrl_mem_req_addr(ctrl_mem_req_addr), .ctrl_mem_req_rdata(ctrl_mem_req_rdata),
    .dict1_write_enable(dict1_write_enable), .dict1_write_val(dict1_write_val),
    .dict2_write_enable(dict2_write_enable), .dict2_write_val(dict2_write_val),
    .dict3_write_enable(dict3_write_enable), .dict3_write_val(dict3_write_val),
    .load_done(load_done), .load_error(load_error), .entries_loaded(entries_loaded)
  );

  always #5 clk = ~clk;

  // Memory image (word 0 sits at 0x1000); outside the image, data echoes the address.
  logic [31:0] img [0:299];
  logic [31:0] rd_off_s;
  always_comb begin
    rd_off_s = mem_req_addr - 32'h0000_1000;
    if (mem_req_addr >= 32'h0000_1000 && rd_off_s < 32'd1200) mem_req_rdata = img[rd_off_s[10:2]];
    else mem_req_rdata = {mem_req_addr[15:0], 16'hA5C3};
  end

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, stall_n = 0, wait_cnt = 0;
  int done_cyc, stab_viol, multi_viol, mux_viol;
  logic [31:0] prev_addr;
  logic        prev_stall;
  logic [31:0] xfer_addr_q[$];
  int          xfer_cyc_q[$];
  int          wr_dict_q[$];
  logic [31:0] wr_val_q[$];
  int          wr_cyc_q[$];
  logic [31:0] exp_addr_q[$];
  int          exp_dict_q[$];
  logic [31:0] exp_val_q[$];

  typedef struct {
    logic [31:0] hdr;
    int          stall;
    bit          exp_done;
    bit          exp_err;
    int          exp_entries;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder and bus/dictionary-write logger.
  initial forever begin
    @(negedge clk);
    if (mem_req_valid && !reset) begin
      if (wait_cnt >= stall_n) begin mem_req_ready = 1'b1; wait_cnt = 0; end
      else begin mem_req_ready = 1'b0; wait_cnt++; end
    end else begin
      mem_req_ready = 1'b0;
      wait_cnt = 0;
    end
    if (!reset) begin
      if (mem_req_valid && mem_req_ready && !load_done) begin
        xfer_addr_q.push_back(mem_req_addr);
        xfer_cyc_q.push_back(cyc);
      end
      if (prev_stall && (!mem_req_valid || mem_req_addr != prev_addr)) stab_viol++;
      prev_stall = mem_req_valid && !mem_req_ready && !load_done;
      prev_addr  = mem_req_addr;
      if (int'(dict1_write_enable) + int'(dict2_write_enable) + int'(dict3_write_enable) > 1)
        multi_viol++;
      if (dict1_write_enable) begin wr_dict_q.push_back(1); wr_val_q.push_back(32'(dict1_write_val)); wr_cyc_q.push_back(cyc); end
      if (dict2_write_enable) begin wr_dict_q.push_back(2); wr_val_q.push_back(32'(dict2_write_val)); wr_cyc_q.push_back(cyc); end
      if (dict3_write_enable) begin wr_dict_q.push_back(3); wr_val_q.push_back(32'(dict3_write_val)); wr_cyc_q.push_back(cyc); end
      if (load_done && done_cyc < 0) done_cyc = cyc;
      if (!load_done && (ctrl_mem_req_ready || ctrl_mem_req_rdata != 32'h0)) mux_viol++;
    end
  end

  // Reference: what the image should produce, derived from the header fields alone.
  task automatic build_model(output bit err);
    int n1, n2, n3, k;
    n1 = int'(img[0] & 32'h3FF);
    n2 = int'((img[0] >> 10) & 32'h3FF);
    n3 = int'((img[0] >> 20) & 32'h3FF);
    err = (n1 > 8) || (n2 > 256) || (n3 > 32);
    exp_addr_q.delete(); exp_dict_q.delete(); exp_val_q.delete();
    exp_addr_q.push_back(32'h0000_1000);
    if (!err) begin
      for (int i = 1; i <= n1 + n2 + n3; i++) exp_addr_q.push_back(32'h0000_1000 + 32'(4 * i));
      k = 1;
      for (int i = 0; i < n1; i++) begin exp_dict_q.push_back(1); exp_val_q.push_back(img[k] % 128);   k++; end
      for (int i = 0; i < n2; i++) begin exp_dict_q.push_back(2); exp_val_q.push_back(img[k] % 32768); k++; end
      for (int i = 0; i < n3; i++) begin exp_dict_q.push_back(3); exp_val_q.push_back(img[k] % 1024);  k++; end
    end
  endtask

  task automatic clear_logs();
    xfer_addr_q.delete(); xfer_cyc_q.delete();
    wr_dict_q.delete(); wr_val_q.delete(); wr_cyc_q.delete();
    done_cyc = -1; stab_viol = 0; multi_viol = 0; mux_viol = 0; prev_stall = 1'b0;
  endtask

  task automatic start_run(input logic [31:0] hdr, input int stall);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_outputs_zero", |{mem_req_valid, mem_req_addr, ctrl_mem_req_ready, ctrl_mem_req_rdata,
        dict1_write_enable, dict2_write_enable, dict3_write_enable, dict1_write_val, dict2_write_val,
        dict3_write_val, load_done, load_error, entries_loaded}, 64'd0);
    img[0] = hdr;
    for (int i = 1; i < 300; i++) img[i] = $urandom;
    stall_n = stall;
    ctrl_mem_req_valid = 1'b1;
    ctrl_mem_req_addr  = 32'h0000_0040;
    repeat (2) @(negedge clk);
    clear_logs();
    reset = 1'b0;
  endtask

  task automatic finish_run(input bit exp_done, input bit exp_err, input int exp_entries);
    int waited;
    bit m_err;
    build_model(m_err);
    waited = 0;
    while (!(load_done || load_error) && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    chk("terminal_reached", 64'(load_done || load_error), 64'd1);
    repeat (5) @(negedge clk);
    #1;
    chk("load_done", 64'(load_done), 64'(exp_done));
    chk("load_error", 64'(load_error), 64'(exp_err));
    chk("entries_loaded", 64'(entries_loaded), 64'(exp_entries));
    chk("n_requests", 64'(xfer_addr_q.size()), 64'(exp_addr_q.size()));
    for (int i = 0; i < xfer_addr_q.size() && i < exp_addr_q.size(); i++)
      chk("req_addr", 64'(xfer_addr_q[i]), 64'(exp_addr_q[i]));
    chk("n_writes", 64'(wr_dict_q.size()), 64'(exp_dict_q.size()));
    for (int i = 0; i < wr_dict_q.size() && i < exp_dict_q.size(); i++) begin
      chk("write_dict", 64'(wr_dict_q[i]), 64'(exp_dict_q[i]));
      chk("write_val", 64'(wr_val_q[i]), 64'(exp_val_q[i]));
    end
    if (xfer_cyc_q.size() == wr_cyc_q.size() + 1)
      for (int i = 0; i < wr_cyc_q.size(); i++)
        chk("write_timing", 64'(wr_cyc_q[i]), 64'(xfer_cyc_q[i+1] + 1));
    if (exp_done && wr_cyc_q.size() > 0) chk("done_with_last_pulse", 64'(done_cyc), 64'(wr_cyc_q[$]));
    if (exp_done && wr_cyc_q.size() == 0 && xfer_cyc_q.size() > 0)
      chk("done_after_header", 64'(done_cyc), 64'(xfer_cyc_q[0] + 1));
    chk("stall_stability", 64'(stab_viol), 64'd0);
    chk("one_write_per_cycle", 64'(multi_viol), 64'd0);
    chk("ctrl_stalled_while_loading", 64'(mux_viol), 64'd0);
    if (exp_err) begin
      chk("err_mem_valid", 64'(mem_req_valid), 64'd0);
      chk("err_ctrl_ready", 64'(ctrl_mem_req_ready), 64'd0);
    end
    if (exp_done) begin
      stall_n = 0;
      @(negedge clk);
      ctrl_mem_req_addr = 32'h0000_0080;
      #1;
      chk("pass_addr", 64'(mem_req_addr), 64'h80);
      chk("pass_valid", 64'(mem_req_valid), 64'd1);
      chk("pass_rdata", 64'(ctrl_mem_req_rdata), 64'h0080_A5C3);
      @(negedge clk);
      #1;
      chk("pass_ready", 64'(ctrl_mem_req_ready), 64'd1);
      ctrl_mem_req_valid = 1'b0;
      #1;
      chk("pass_valid_low", 64'(mem_req_valid), 64'd0);
      ctrl_mem_req_valid = 1'b1;
    end
  endtask

  initial begin
    int n1, n2, n3, waited, d2;
    bit m_err;
    logic [31:0] h;

    vecs[0] = '{32'h0010_0C02, 0, 1'b1, 1'b0, 6};    // n1=2 n2=3 n3=1
    vecs[1] = '{32'h0000_0000, 0, 1'b1, 1'b0, 0};    // empty image
    vecs[2] = '{32'h0004_0400, 0, 1'b0, 1'b1, 0};    // n2=257
    vecs[3] = '{32'h0010_0401, 5, 1'b1, 1'b0, 3};    // one each, slow memory
    vecs[4] = '{32'h0204_0008, 0, 1'b1, 1'b0, 296};  // every dictionary full
    vecs[5] = '{32'h0000_0009, 1, 1'b0, 1'b1, 0};    // n1=9
    vecs[6] = '{32'h0210_0000, 0, 1'b0, 1'b1, 0};    // n3=33
    vecs[7] = '{32'hC000_0401, 2, 1'b1, 1'b0, 2};    // top bits ignored
    vecs[8] = '{32'h0030_0000, 1, 1'b1, 1'b0, 3};    // dict3 only

    for (int v = 0; v < 9; v++) begin
      start_run(vecs[v].hdr, vecs[v].stall);
      finish_run(vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_entries);
    end

    for (int r = 0; r < 6; r++) begin
      n1 = $urandom_range(0, 9);
      n2 = $urandom_range(0, 40);
      n3 = $urandom_range(0, 34);
      h  = (32'($urandom_range(0, 3)) << 30) | (32'(n3) << 20) | (32'(n2) << 10) | 32'(n1);
      start_run(h, $urandom_range(0, 2));
      start = $urandom_range(0, 1) == 1;
      build_model(m_err);
      finish_run(!m_err, m_err, m_err ? 0 : n1 + n2 + n3);
      start = 1'b0;
    end

    // Reset after the 2nd dict2 write: outputs clear at once, then the load restarts.
    start_run(32'h0010_0C02, 0);
    waited = 0;
    d2 = 0;
    while (d2 < 2 && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
      d2 = 0;
      foreach (wr_dict_q[i]) if (wr_dict_q[i] == 2) d2++;
    end
    chk("saw_second_dict2_write", 64'(d2), 64'd2);
    reset = 1'b1;
    #1;
    chk("midload_reset_zero", |{mem_req_valid, mem_req_addr, ctrl_mem_req_ready, dict1_write_enable,
        dict2_write_enable, dict3_write_enable, dict1_write_val, dict2_write_val, dict3_write_val,
        load_done, load_error, entries_loaded}, 64'd0);
    repeat (2) @(negedge clk);
    clear_logs();
    reset = 1'b0;
    waited = 0;
    while (!mem_req_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("restart_valid", 64'(mem_req_valid), 64'd1);
    chk("restart_addr", 64'(mem_req_addr), 64'h1000);
    finish_run(1'b1, 1'b0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
